// File: rtl/dram_read_responder_pkg.sv
// Shared widths and packed request/tag/response records for the DRAM sample-read responder.
package dram_read_pkg;
   localparam int SAMPLE_ADDR_W = 24;
   localparam int PERIOD_W      = 14;
   localparam int WORD_ADDR_W   = 21;
   localparam int LANE_W        = 3;
   localparam int SAMPLE_W      = 16;
   localparam int WORD_W        = 128;

   typedef struct packed {
      logic [SAMPLE_ADDR_W-1:0] addr;
      logic [PERIOD_W-1:0]      period;
   } dram_req_t;

   typedef struct packed {
      logic [LANE_W-1:0]   lane;
      logic [PERIOD_W-1:0] period;
      logic                last;
   } dram_tag_t;

   typedef struct packed {
      logic [PERIOD_W-1:0] period;
      logic [SAMPLE_W-1:0] sample;
      logic                last;
   } dram_resp_t;

   function automatic logic [SAMPLE_W-1:0] lane_sample(input logic [WORD_W-1:0] word,
                                                       input logic [LANE_W-1:0] lane);
      return word[SAMPLE_W*lane +: SAMPLE_W];
   endfunction
endpackage

// File: rtl/dram_read_responder_if.sv
// Request stream, DRAM command/read-data channel and response stream of the read responder.
interface dram_read_responder_if;
   import dram_read_pkg::*;
   logic                   req_axis_tvalid;
   logic                   req_axis_tready;
   logic [$bits(dram_req_t)-1:0] req_axis_tdata;
   logic                   req_axis_tlast;
   logic                   mem_cmd_valid;
   logic                   mem_cmd_ready;
   logic [WORD_ADDR_W-1:0] mem_cmd_addr;
   logic                   mem_rd_valid;
   logic [WORD_W-1:0]      mem_rd_data;
   logic                   resp_axis_tvalid;
   logic                   resp_axis_tready;
   logic [PERIOD_W+SAMPLE_W-1:0] resp_axis_tdata;
   logic                   resp_axis_tlast;
   logic                   rd_err;

   modport slave (
      input  req_axis_tvalid, req_axis_tdata, req_axis_tlast, mem_cmd_ready,
             mem_rd_valid, mem_rd_data, resp_axis_tready,
      output req_axis_tready, mem_cmd_valid, mem_cmd_addr, resp_axis_tvalid,
             resp_axis_tdata, resp_axis_tlast, rd_err
   );

   modport master (
      output req_axis_tvalid, req_axis_tdata, req_axis_tlast, mem_cmd_ready,
             mem_rd_valid, mem_rd_data, resp_axis_tready,
      input  req_axis_tready, mem_cmd_valid, mem_cmd_addr, resp_axis_tvalid,
             resp_axis_tdata, resp_axis_tlast, rd_err
   );
endinterface

// File: rtl/dram_read_responder_sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
module sync_fwft_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_din,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_dout,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr, r_rd;
   logic [CW-1:0]    r_cnt;
   logic             w_push, w_pop;

   // A push into a full FIFO is only honoured when the head leaves in the same cycle.
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_dout  = r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      end
   end
endmodule

// File: rtl/dram_read_responder.sv
// Turns sample-read requests into DRAM word reads and returns the addressed 16-bit lane in order.
module dram_read_responder
   import dram_read_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 8,
   parameter int WORD_WIDTH      = 128
) (
   input logic                  clk,
   input logic                  rst,
   dram_read_responder_if.slave bus
);
   localparam int CW = $clog2(MAX_OUTSTANDING+1);

   logic [CW-1:0]          r_credits;
   logic                   r_cmd_valid;
   logic [WORD_ADDR_W-1:0] r_cmd_addr;
   logic                   r_rd_err;

   dram_req_t              w_req;
   dram_tag_t              w_tag_in, w_tag_out;
   dram_resp_t             w_resp_in, w_resp_out;
   logic [WORD_WIDTH-1:0]  w_word;
   logic                   w_ready, w_accept, w_resp_hs, w_tag_pop, w_stray;
   logic                   w_tag_full, w_tag_empty, w_resp_full, w_resp_empty;
   logic [CW-1:0]          w_tag_cnt, w_resp_cnt;

   assign w_req  = dram_req_t'(bus.req_axis_tdata);
   assign w_word = bus.mem_rd_data;

   // Credits cover both FIFOs, so neither can overflow and read data never needs backpressure.
   assign w_ready   = !rst && (r_credits < CW'(MAX_OUTSTANDING)) && !w_tag_full &&
                      (!r_cmd_valid || bus.mem_cmd_ready);
   assign w_accept  = bus.req_axis_tvalid && w_ready;
   assign w_resp_hs = !w_resp_empty && bus.resp_axis_tready;
   assign w_tag_pop = bus.mem_rd_valid && !w_tag_empty;
   assign w_stray   = bus.mem_rd_valid && w_tag_empty;

   assign w_tag_in  = '{lane: w_req.addr[LANE_W-1:0], period: w_req.period, last: bus.req_axis_tlast};
   assign w_resp_in = '{period: w_tag_out.period,
                        sample: lane_sample(w_word, w_tag_out.lane),
                        last:   w_tag_out.last};

   sync_fwft_fifo #(.WIDTH($bits(dram_tag_t)), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .clk(clk), .rst(rst), .i_push(w_accept), .i_din(w_tag_in), .i_pop(w_tag_pop),
      .o_dout(w_tag_out), .o_full(w_tag_full), .o_empty(w_tag_empty), .o_count(w_tag_cnt)
   );

   sync_fwft_fifo #(.WIDTH($bits(dram_resp_t)), .DEPTH(MAX_OUTSTANDING)) u_resp_fifo (
      .clk(clk), .rst(rst), .i_push(w_tag_pop), .i_din(w_resp_in), .i_pop(w_resp_hs),
      .o_dout(w_resp_out), .o_full(w_resp_full), .o_empty(w_resp_empty), .o_count(w_resp_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_credits   <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd_addr  <= '0;
         r_rd_err    <= 1'b0;
      end else begin
         if (w_accept && !w_resp_hs)      r_credits <= r_credits + 1'b1;
         else if (!w_accept && w_resp_hs) r_credits <= r_credits - 1'b1;

         if (w_accept) begin
            r_cmd_valid <= 1'b1;
            r_cmd_addr  <= w_req.addr[SAMPLE_ADDR_W-1:LANE_W];
         end else if (bus.mem_cmd_ready) begin
            r_cmd_valid <= 1'b0;
         end

         if (w_stray) r_rd_err <= 1'b1;
      end
   end

   assign bus.req_axis_tready  = w_ready;
   assign bus.mem_cmd_valid    = r_cmd_valid;
   assign bus.mem_cmd_addr     = r_cmd_addr;
   assign bus.rd_err           = r_rd_err;
   // Head is masked while empty so the idle response bus reads as zero.
   assign bus.resp_axis_tvalid = !w_resp_empty;
   assign bus.resp_axis_tdata  = w_resp_empty ? '0 : {w_resp_out.period, w_resp_out.sample};
   assign bus.resp_axis_tlast  = !w_resp_empty && w_resp_out.last;
endmodule

// File: tb/tb_dram_read_responder.sv
// Scoreboard bench: a behavioural DRAM holds sample data by sample address; responses are checked in order.
module tb_dram_read_responder;
   import dram_read_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dram_read_responder_if bus();
   dram_read_responder #(.MAX_OUTSTANDING(8), .WORD_WIDTH(128)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0, errors = 0;
   int cyc = 0, n_acc = 0, n_resp = 0, lat_max = 0, last_due = 0;
   bit cmd_rand = 0, cmd_hold = 0, rd_hold = 0, stray_req = 0, resp_rand = 0, resp_force = 1;

   typedef struct { logic [20:0] waddr; int due; } pend_t;
   pend_t       pend_q[$];
   logic [30:0] exp_q[$];
   int          resp_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents defined per sample address; a word is just eight consecutive samples.
   function automatic logic [15:0] mem_sample(input logic [23:0] sa);
      logic [31:0] h;
      if (sa == 24'h000013) return 16'hBEEF;
      if (sa >= 24'h000100 && sa <= 24'h000107) return 16'h1000 + 16'(sa - 24'h000100);
      h = {8'h00, sa} * 32'h9E3779B1;
      return h[31:16] ^ h[15:0];
   endfunction

   function automatic logic [127:0] mem_word(input logic [20:0] wa);
      logic [127:0] w;
      w = '0;
      for (int k = 0; k < 8; k++) w[16*k +: 16] = mem_sample({wa, 3'(k)});
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(negedge clk); #2;
   endtask

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [23:0] a, input logic [13:0] p, input logic l);
      int  n;
      logic acc;
      n = 0; acc = 0;
      bus.req_axis_tvalid = 1'b1;
      bus.req_axis_tdata  = {a, p};
      bus.req_axis_tlast  = l;
      while (!acc && n < 100) begin
         @(negedge clk); acc = bus.req_axis_tready;
         @(posedge clk); #1; n++;
      end
      bus.req_axis_tvalid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL req_accept addr %h got none want accept within 100 cycles", a);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 500) begin tick(); n++; end
      chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
      sync();
   endtask

   task automatic chk_rst_state(input string t);
      chk({t, "_cmd_valid"},  bus.mem_cmd_valid,    0);
      chk({t, "_cmd_addr"},   bus.mem_cmd_addr,     0);
      chk({t, "_resp_valid"}, bus.resp_axis_tvalid, 0);
      chk({t, "_resp_data"},  bus.resp_axis_tdata,  0);
      chk({t, "_resp_last"},  bus.resp_axis_tlast,  0);
      chk({t, "_rd_err"},     bus.rd_err,           0);
   endtask

   // DRAM controller model: command ready, in-order beats after a random latency.
   initial begin
      bus.mem_cmd_ready = 1'b1;
      bus.mem_rd_valid  = 1'b0;
      bus.mem_rd_data   = '0;
      forever begin
         @(posedge clk); #1;
         bus.mem_cmd_ready = cmd_hold ? 1'b0 : (cmd_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
         bus.mem_rd_valid  = 1'b0;
         if (stray_req) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = {4{32'hDEADBEEF}};
            stray_req = 0;
         end else if (!rd_hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = mem_word(pend_q[0].waddr);
            void'(pend_q.pop_front());
         end
      end
   end

   initial begin
      bus.resp_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.resp_axis_tready = resp_rand ? ($urandom_range(0, 3) != 0) : resp_force;
      end
   end

   // Monitor: handshakes seen at the negedge complete on the following posedge.
   initial begin
      dram_req_t   r;
      logic [30:0] e;
      pend_t       pe;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.req_axis_tvalid && bus.req_axis_tready) begin
               r = dram_req_t'(bus.req_axis_tdata);
               exp_q.push_back({r.period, mem_sample(r.addr), bus.req_axis_tlast});
               n_acc++;
            end
            if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
               pe.waddr = bus.mem_cmd_addr;
               pe.due   = cyc + 1 + $urandom_range(0, lat_max);
               if (pe.due < last_due) pe.due = last_due;
               last_due = pe.due;
               pend_q.push_back(pe);
            end
            if (bus.resp_axis_tvalid && bus.resp_axis_tready) begin
               n_resp++;
               resp_cyc.push_back(cyc);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL resp_unexpected got %h want no response", bus.resp_axis_tdata);
               end else begin
                  e = exp_q.pop_front();
                  if ({bus.resp_axis_tdata, bus.resp_axis_tlast} !== e) begin
                     errors++;
                     $display("FAIL resp_data got %h/%0d want %h/%0d",
                              bus.resp_axis_tdata, bus.resp_axis_tlast, e[30:1], e[0]);
                  end
               end
            end
            if (dut.u_tag_fifo.o_full) begin
               checks++;
               if (dut.u_tag_fifo.i_push && !dut.u_tag_fifo.i_pop) begin
                  errors++; $display("FAIL tag_overflow got push-when-full want none");
               end
            end
            if (dut.u_resp_fifo.o_full) begin
               checks++;
               if (dut.u_resp_fifo.i_push && !dut.u_resp_fifo.i_pop) begin
                  errors++; $display("FAIL resp_overflow got push-when-full want none");
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, a0, r0, k;
      logic [23:0] a;
      bus.req_axis_tvalid = 1'b0;
      bus.req_axis_tdata  = '0;
      bus.req_axis_tlast  = 1'b0;
      #1 rst = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      tick();
      chk("rst_req_tready", bus.req_axis_tready, 0);
      chk_rst_state("rst");
      sync(); rst = 1'b0;
      tick();
      chk("post_rst_req_tready", bus.req_axis_tready, 1);
      sync();

      // Single read: lane 3 of word 2
      send(24'h000013, 14'h0A3, 1'b1);
      tick();
      chk("single_cmd_valid", bus.mem_cmd_valid, 1);
      chk("single_cmd_addr", bus.mem_cmd_addr, 21'h000002);
      n = 0;
      while (!bus.mem_rd_valid && n < 20) begin tick(); n++; end
      chk("single_beat_seen", bus.mem_rd_valid, 1);
      tick();
      chk("single_resp_valid", bus.resp_axis_tvalid, 1);
      chk("single_resp_data", bus.resp_axis_tdata, {14'h0A3, 16'hBEEF});
      drain();

      // Lane sweep at full rate
      for (int i = 0; i < 8; i++) send(24'h000100 + 24'(i), 14'(i), i == 7);
      drain();
      k = resp_cyc.size();
      n = 0;
      for (int i = k - 7; i < k; i++) if (resp_cyc[i] - resp_cyc[i-1] != 1) n++;
      chk("sweep_one_per_cycle_gaps", n, 0);

      // Credit exhaustion
      resp_force = 0; sync(); sync();
      a0 = n_acc;
      for (int i = 0; i < 8; i++) send(24'h002000 + 24'(i*5), 14'h100 + 14'(i), 1'b0);
      bus.req_axis_tvalid = 1'b1;
      bus.req_axis_tdata  = {24'h003000, 14'h2AA};
      bus.req_axis_tlast  = 1'b0;
      repeat (20) tick();
      chk("credit_accepted", n_acc - a0, 8);
      chk("credit_tready_low", bus.req_axis_tready, 0);
      sync();
      resp_force = 1;
      send(24'h003000, 14'h2AA, 1'b0);
      send(24'h003009, 14'h2AB, 1'b1);
      drain();
      chk("credit_total_accepted", n_acc - a0, 10);

      // Command backpressure
      cmd_hold = 1; sync(); sync();
      send(24'h0ABCDE, 14'h3FFF, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_cmd_valid", bus.mem_cmd_valid, 1);
         chk("bp_cmd_addr", bus.mem_cmd_addr, 21'(24'h0ABCDE >> 3));
         chk("bp_req_tready", bus.req_axis_tready, 0);
      end
      sync();
      cmd_hold = 0;
      drain();

      // Randomized traffic
      cmd_rand = 1; resp_rand = 1; lat_max = 4;
      r0 = n_resp;
      for (int i = 0; i < 150; i++) begin
         a = 24'($urandom);
         send(a, 14'($urandom_range(0, 16383)), 1'($urandom));
         repeat ($urandom_range(0, 2)) sync();
      end
      cmd_rand = 0; resp_rand = 0; resp_force = 1;
      drain();
      chk("rand_resp_count", n_resp - r0, 150);
      chk("rand_rd_err_clear", bus.rd_err, 0);
      lat_max = 0;

      // Stray beat
      r0 = n_resp;
      stray_req = 1;
      repeat (3) tick();
      chk("stray_rd_err", bus.rd_err, 1);
      chk("stray_no_resp", n_resp - r0, 0);
      repeat (5) tick();
      chk("stray_rd_err_sticky", bus.rd_err, 1);
      sync();

      // Reset with reads in flight
      rd_hold = 1; resp_force = 0; sync(); sync();
      for (int i = 0; i < 4; i++) send(24'h004000 + 24'(i*9), 14'h055, 1'b0);
      rst = 1'b1;
      exp_q.delete(); pend_q.delete(); last_due = 0;
      tick();
      chk("midrst_req_tready", bus.req_axis_tready, 0);
      chk_rst_state("midrst");
      tick();
      sync();
      rst = 1'b0; rd_hold = 0; resp_force = 1;
      tick();
      chk("midrst_release_tready", bus.req_axis_tready, 1);
      sync();
      r0 = n_resp;
      send(24'h000055, 14'h1234, 1'b1);
      drain();
      chk("midrst_resp_count", n_resp - r0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
